// File: rtl/fork_n_sync_if.sv
// fork_n_sync_if -- handshake bundle for the fork_n_sync broadcast stage.
//
// One upstream valid/ready channel (valid_i, ready_o, data_i) fans out to
// N_OUT downstream channels (valid_o[k], ready_i[k]) sharing data_o.
// Signal names keep the block's view: *_i are driven by the environment,
// *_o by the block.
//
// Optional: FORK_SYNC_MASK_EN adds mask_i, the per-transaction destination set.
//
// Modports:
//   master -- environment side (drives valid_i, data_i, mask_i, ready_i)
//   slave  -- the fork_n_sync block (drives ready_o, valid_o, data_o)

interface fork_n_sync_if #(
    parameter int N_OUT = 3,
    parameter int WIDTH = 32
);
    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] data_i;
`ifdef FORK_SYNC_MASK_EN
    logic [N_OUT-1:0] mask_i;
`endif
    logic [N_OUT-1:0] valid_o;
    logic [N_OUT-1:0] ready_i;
    logic [WIDTH-1:0] data_o;

    modport master (
        output valid_i,
        output data_i,
`ifdef FORK_SYNC_MASK_EN
        output mask_i,
`endif
        output ready_i,
        input  ready_o,
        input  valid_o,
        input  data_o
    );

    modport slave (
        input  valid_i,
        input  data_i,
`ifdef FORK_SYNC_MASK_EN
        input  mask_i,
`endif
        input  ready_i,
        output ready_o,
        output valid_o,
        output data_o
    );
endinterface

// File: rtl/fork_n_sync.sv
// fork_n_sync -- one-deep register stage that broadcasts each accepted
// transaction to N_OUT downstream channels (eager fork). Every channel
// completes independently; the stage frees (or is refilled back-to-back)
// once every destination channel has taken the payload.
//
// Optional: FORK_SYNC_MASK_EN -- when defined, bus.mask_i selects which
// channels receive each transaction; when undefined every channel does and
// no destination register exists.
//
// Ports:
//   clk_i   -- clock, all state updates on the rising edge
//   rst_ni  -- asynchronous active-low reset
//   bus     -- fork_n_sync_if.slave: valid_i/ready_o/data_i upstream,
//              valid_o[k]/ready_i[k]/data_o downstream, mask_i (optional)

module fork_n_sync #(
    parameter int N_OUT = 3,
    parameter int WIDTH = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    fork_n_sync_if.slave  bus
);

    if (N_OUT < 2 || N_OUT > 8) begin : g_bad_n_out
        $error("fork_n_sync: N_OUT must be in 2..8");
    end
    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
        $error("fork_n_sync: WIDTH must be in 1..64");
    end

    logic             full_q, full_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [N_OUT-1:0] done_q, done_d;
    logic [N_OUT-1:0] dest;
    logic [N_OUT-1:0] valid;
    logic [N_OUT-1:0] served;
    logic             complete;
    logic             ready;
    logic             accept;

`ifdef FORK_SYNC_MASK_EN
    logic [N_OUT-1:0] dest_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dest_q <= '0;
        end else if (accept) begin
            dest_q <= bus.mask_i;
        end
    end

    assign dest = dest_q;
`else
    assign dest = '1;
`endif

    // Outputs come straight from registers: no path from valid_i/ready_i.
    assign valid       = {N_OUT{full_q}} & dest & ~done_q;
    assign bus.valid_o = valid;
    assign bus.data_o  = data_q;

    assign served   = valid & bus.ready_i;
    // A channel is finished if it was never a destination, already took the
    // payload, or takes it this cycle. An empty mask completes immediately.
    assign complete = &(~dest | done_q | bus.ready_i);
    assign ready    = ~full_q | complete;
    assign bus.ready_o = ready;
    assign accept   = bus.valid_i & ready;

    // NOTE: every variable gets its hold value first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        done_d = done_q;
        if (accept) begin
            // Covers complete-and-accept too: replacement with no bubble.
            full_d = 1'b1;
            data_d = bus.data_i;
            done_d = '0;
        end else if (full_q && complete) begin
            full_d = 1'b0;
            done_d = '0;
        end else if (full_q) begin
            done_d = done_q | served;
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    // NOTE: the payload register is reset as well, so data_o reads 0 out of
    // reset instead of stale or unknown data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_q <= 1'b0;
            data_q <= '0;
            done_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
            done_q <= done_d;
        end
    end

endmodule

// File: tb/tb_fork_n_sync.sv
// tb_fork_n_sync -- self-checking bench for fork_n_sync.
// Two instances share clk/rst: u_dut3 (N_OUT=3, WIDTH=32) for the directed
// scenarios and random traffic, u_dut8 (N_OUT=8, WIDTH=1) for 1000 random
// transactions. A transaction-level model tracks, per instance, the current
// payload and the set of channels still owed it, plus per-channel FIFOs of
// every payload each channel must receive, in order, exactly once.

`timescale 1ns/1ps

module tb_fork_n_sync;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    fork_n_sync_if #(.N_OUT(3), .WIDTH(32)) b3 ();
    fork_n_sync_if #(.N_OUT(8), .WIDTH(1))  b8 ();

    fork_n_sync #(.N_OUT(3), .WIDTH(32)) u_dut3 (.clk_i(clk), .rst_ni(rst_ni), .bus(b3));
    fork_n_sync #(.N_OUT(8), .WIDTH(1))  u_dut8 (.clk_i(clk), .rst_ni(rst_ni), .bus(b8));

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state, index 0 = u_dut3, 1 = u_dut8.
    logic [7:0]  m_pending [2];
    logic [63:0] m_data    [2];
    bit          m_has     [2];
    logic [63:0] chq       [16][$];
    int          pushed    [16];
    int          delivered [16];
    int          n_acc     [2];

    // Pre-edge view of the driven instance from the last step.
    logic [7:0]  obs_valid;
    logic        obs_ready;
    logic [63:0] obs_data;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            m_pending[d] = '0;
            m_data[d]    = '0;
            m_has[d]     = 1'b0;
        end
        // Only the in-flight transaction can be undelivered; reset drops it.
        for (int i = 0; i < 16; i++) begin
            pushed[i] -= chq[i].size();
            chq[i].delete();
        end
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        #1;
        check("rst_valid3", {5'b0, b3.valid_o}, 64'h0);
        check("rst_ready3", {63'b0, b3.ready_o}, 64'h1);
        check("rst_data3",  {32'b0, b3.data_o}, 64'h0);
        check("rst_valid8", {56'b0, b8.valid_o}, 64'h0);
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;
    endtask

    // One clock cycle on instance d: drive, check at the falling edge,
    // advance the model on the rising edge.
    task automatic step(input int d, input bit v, input logic [63:0] data,
                        input logic [7:0] mask, input logic [7:0] rdy);
        logic [7:0]  nmask, exp_valid, dest;
        logic [63:0] dmask, exp_d;
        bit          exp_ready;
        nmask = (d == 1) ? 8'hFF : 8'h07;
        dmask = (d == 1) ? 64'h1 : 64'hFFFF_FFFF;
        b3.valid_i = (d == 0) ? v : 1'b0;
        b3.data_i  = data[31:0];
        b3.ready_i = (d == 0) ? rdy[2:0] : 3'b000;
        b8.valid_i = (d == 1) ? v : 1'b0;
        b8.data_i  = data[0];
        b8.ready_i = (d == 1) ? rdy : 8'h00;
`ifdef FORK_SYNC_MASK_EN
        b3.mask_i  = mask[2:0];
        b8.mask_i  = mask;
`endif
        @(negedge clk);
        obs_valid = (d == 1) ? b8.valid_o : {5'b0, b3.valid_o};
        obs_ready = (d == 1) ? b8.ready_o : b3.ready_o;
        obs_data  = (d == 1) ? {63'b0, b8.data_o} : {32'b0, b3.data_o};

        exp_valid = m_pending[d];
        exp_ready = ((m_pending[d] & ~rdy & nmask) == 8'h00);
        check("valid_o", {56'b0, obs_valid}, {56'b0, exp_valid});
        check("ready_o", {63'b0, obs_ready}, {63'b0, exp_ready});
        if (m_has[d]) check("data_o", obs_data, m_data[d]);
        for (int k = 0; k < 8; k++) begin
            if (exp_valid[k] && rdy[k]) begin
                if (chq[d*8+k].size() == 0) begin
                    check("extra_delivery", 64'h1, 64'h0);
                end else begin
                    exp_d = chq[d*8+k].pop_front();
                    check("delivery_order", obs_data, exp_d);
                    delivered[d*8+k]++;
                end
            end
        end

        @(posedge clk);
        m_pending[d] = m_pending[d] & ~(exp_valid & rdy);
        if (v && exp_ready) begin
`ifdef FORK_SYNC_MASK_EN
            dest = mask & nmask;
`else
            dest = nmask;
`endif
            m_has[d]     = 1'b1;
            m_data[d]    = data & dmask;
            m_pending[d] = dest;
            n_acc[d]++;
            for (int k = 0; k < 8; k++) begin
                if (dest[k]) begin
                    chq[d*8+k].push_back(data & dmask);
                    pushed[d*8+k]++;
                end
            end
        end else if (exp_ready) begin
            m_has[d] = 1'b0;
        end
        #1;
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < 16; i++) begin
            pushed[i] = 0;
            delivered[i] = 0;
        end
        n_acc[0] = 0;
        n_acc[1] = 0;
        b3.valid_i = 1'b0; b3.data_i = '0; b3.ready_i = '0;
        b8.valid_i = 1'b0; b8.data_i = '0; b8.ready_i = '0;
`ifdef FORK_SYNC_MASK_EN
        b3.mask_i = '0;
        b8.mask_i = '0;
`endif
        do_reset();

        // Streaming at full rate; first accept on the first edge after reset.
        step(0, 1, 64'h11, 8'h07, 8'h07);
        check("first_accept_ready", {63'b0, obs_ready}, 64'h1);
        step(0, 1, 64'h22, 8'h07, 8'h07);
        check("stream_v1", {56'b0, obs_valid}, 64'h7);
        check("stream_d1", obs_data, 64'h11);
        check("stream_r1", {63'b0, obs_ready}, 64'h1);
        step(0, 1, 64'h33, 8'h07, 8'h07);
        check("stream_v2", {56'b0, obs_valid}, 64'h7);
        check("stream_d2", obs_data, 64'h22);
        step(0, 0, 64'h0, 8'h07, 8'h07);
        check("stream_v3", {56'b0, obs_valid}, 64'h7);
        check("stream_d3", obs_data, 64'h33);
        check("stream_r3", {63'b0, obs_ready}, 64'h1);
        step(0, 0, 64'h0, 8'h07, 8'h07);
        check("stream_idle", {56'b0, obs_valid}, 64'h0);

        // Eager fork: channels complete one by one.
        step(0, 1, 64'hA5, 8'h07, 8'h00);
        step(0, 0, 64'h0, 8'h07, 8'h01);
        check("eager_v0", {56'b0, obs_valid}, 64'h7);
        check("eager_r0", {63'b0, obs_ready}, 64'h0);
        step(0, 0, 64'h0, 8'h07, 8'h04);
        check("eager_v1", {56'b0, obs_valid}, 64'h6);
        check("eager_r1", {63'b0, obs_ready}, 64'h0);
        step(0, 0, 64'h0, 8'h07, 8'h02);
        check("eager_v2", {56'b0, obs_valid}, 64'h2);
        check("eager_r2", {63'b0, obs_ready}, 64'h1);
        step(0, 0, 64'h0, 8'h07, 8'h07);
        check("eager_v3", {56'b0, obs_valid}, 64'h0);

        // Backpressure: 0x5A waits behind 0x3C for 10 cycles.
        step(0, 1, 64'h3C, 8'h07, 8'h00);
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 64'h5A, 8'h07, 8'h00);
            check("stall_ready", {63'b0, obs_ready}, 64'h0);
            check("stall_data", obs_data, 64'h3C);
        end
        step(0, 1, 64'h5A, 8'h07, 8'h07);
        check("unstall_ready", {63'b0, obs_ready}, 64'h1);
        step(0, 0, 64'h0, 8'h07, 8'h07);
        check("unstall_v", {56'b0, obs_valid}, 64'h7);
        check("unstall_d", obs_data, 64'h5A);

`ifdef FORK_SYNC_MASK_EN
        // Masked destinations, including an empty mask.
        step(0, 1, 64'h77, 8'h05, 8'h00);
        step(0, 1, 64'h88, 8'h00, 8'h07);
        check("mask_v101", {56'b0, obs_valid}, 64'h5);
        check("mask_d77", obs_data, 64'h77);
        step(0, 0, 64'h0, 8'h07, 8'h07);
        check("mask_v000", {56'b0, obs_valid}, 64'h0);
        check("mask_r000", {63'b0, obs_ready}, 64'h1);
        check("mask_d88", obs_data, 64'h88);
        step(0, 0, 64'h0, 8'h07, 8'h07);
`endif

        // Reset with channels 0 and 1 done and channel 2 pending.
        step(0, 1, 64'hA5, 8'h07, 8'h00);
        step(0, 0, 64'h0, 8'h07, 8'h03);
        check("pre_rst_v", {56'b0, obs_valid}, 64'h7);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 64'h0, 8'h07, 8'h07);
            check("post_rst_v", {56'b0, obs_valid}, 64'h0);
            check("post_rst_r", {63'b0, obs_ready}, 64'h1);
        end

        // Random traffic on the 3-channel instance.
        for (int i = 0; i < 300; i++) begin
            step(0, $urandom_range(0, 3) != 0, {32'b0, $urandom()},
                 8'($urandom()), 8'($urandom()));
        end

        // 1000 random transactions on the 8-channel, 1-bit instance.
        cyc = 0;
        while (n_acc[1] < 1000 && cyc < 20000) begin
            logic [7:0] r;
            for (int k = 0; k < 8; k++) r[k] = ($urandom_range(0, 3) != 0);
            step(1, $urandom_range(0, 4) != 0, {63'b0, 1'($urandom())},
                 8'($urandom()), r);
            cyc++;
        end
        if (n_acc[1] < 1000) check("accept_budget", 64'(n_acc[1]), 64'd1000);

        // Drain both instances, then every pushed payload must be delivered.
        for (int i = 0; i < 4; i++) step(1, 0, 64'h0, 8'h00, 8'hFF);
        for (int i = 0; i < 4; i++) step(0, 0, 64'h0, 8'h00, 8'h07);
        for (int i = 0; i < 16; i++) begin
            if (i < 3 || i >= 8) begin
                check($sformatf("drained_ch%0d", i), 64'(delivered[i]), 64'(pushed[i]));
                check($sformatf("leftover_ch%0d", i), 64'(chq[i].size()), 64'h0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
